// File: rtl/mse_pkg.sv
// ============================================================================
// Module      : mse_pkg
// Description : Shared register offsets, widths and per-sprite register struct
//               for the multi-sprite engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mse_pkg;

  localparam int CFG_DATA_W = 16;

  localparam logic [4:0] c_reg_x        = 5'd0;
  localparam logic [4:0] c_reg_y        = 5'd1;
  localparam logic [4:0] c_reg_color    = 5'd2;
  localparam logic [4:0] c_reg_enable   = 5'd3;
  localparam logic [4:0] c_reg_row_base = 5'd16;

  localparam logic [5:0] c_reset_color = 6'b110001;

  // Coordinates are held at full config width; only COORD_W low bits are ever nonzero.
  typedef struct packed {
    logic [CFG_DATA_W-1:0] x;
    logic [CFG_DATA_W-1:0] y;
    logic [5:0]            color;
    logic                  enable;
  } sprite_regs_t;

  function automatic sprite_regs_t reset_regs(input int idx, input int coord_w);
    sprite_regs_t regs;
    regs.x      = CFG_DATA_W'((16 * idx) % (1 << coord_w));
    regs.y      = CFG_DATA_W'((8 * idx) % (1 << coord_w));
    regs.color  = c_reset_color;
    regs.enable = (idx == 0);
    return regs;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mse_channel.sv
// ============================================================================
// Module      : mse_channel
// Description : One sprite: shadow/live registers, bitmap and hit detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mse_channel
  import mse_pkg::*;
#(
  parameter int SPRITE_IDX    = 0,
  parameter int SPRITE_WIDTH  = 12,
  parameter int SPRITE_HEIGHT = 12,
  parameter int COORD_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [4:0]            wr_reg,
  input  logic [CFG_DATA_W-1:0] wr_data,
  input  logic                  commit,
  input  logic [COORD_W-1:0]    pixel_x,
  input  logic [COORD_W-1:0]    pixel_y,
  output logic                  hit,
  output logic [5:0]            color
);

  localparam int c_ext_w = CFG_DATA_W + 1;
  typedef logic [c_ext_w-1:0] ext_t;

  localparam sprite_regs_t c_reset_regs = reset_regs(SPRITE_IDX, COORD_W);

  sprite_regs_t r_shadow;
  sprite_regs_t r_live;
  logic [SPRITE_HEIGHT-1:0][SPRITE_WIDTH-1:0] r_bitmap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= c_reset_regs;
      r_live   <= c_reset_regs;
    end else begin
      if (commit) begin
        r_live <= r_shadow;
      end
      if (wr_en) begin
        case (wr_reg)
          c_reg_x:      r_shadow.x      <= CFG_DATA_W'(wr_data[COORD_W-1:0]);
          c_reg_y:      r_shadow.y      <= CFG_DATA_W'(wr_data[COORD_W-1:0]);
          c_reg_color:  r_shadow.color  <= wr_data[5:0];
          c_reg_enable: r_shadow.enable <= wr_data[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitmap <= '0;
    end else if (wr_en) begin
      for (int r = 0; r < SPRITE_HEIGHT; r++) begin
        if (wr_reg == c_reg_row_base + 5'(r)) begin
          r_bitmap[r] <= wr_data[SPRITE_WIDTH-1:0];
        end
      end
    end
  end

  // Bounds in one extra bit so a sprite near the edge is clipped, never wrapped.
  ext_t w_px, w_py, w_x0, w_y0, w_x1, w_y1, w_dx, w_dy;
  logic w_in_x, w_in_y, w_opaque;
  logic [SPRITE_WIDTH-1:0] w_row;

  assign w_px   = ext_t'(pixel_x);
  assign w_py   = ext_t'(pixel_y);
  assign w_x0   = ext_t'(r_live.x);
  assign w_y0   = ext_t'(r_live.y);
  assign w_x1   = w_x0 + ext_t'(SPRITE_WIDTH);
  assign w_y1   = w_y0 + ext_t'(SPRITE_HEIGHT);
  assign w_in_x = (w_px >= w_x0) && (w_px < w_x1);
  assign w_in_y = (w_py >= w_y0) && (w_py < w_y1);
  assign w_dx   = w_px - w_x0;
  assign w_dy   = w_py - w_y0;

  always_comb begin
    w_row    = '0;
    w_opaque = 1'b0;
    for (int r = 0; r < SPRITE_HEIGHT; r++) begin
      if (w_dy == ext_t'(r)) begin
        w_row = r_bitmap[r];
      end
    end
    for (int c = 0; c < SPRITE_WIDTH; c++) begin
      if (w_dx == ext_t'(c)) begin
        w_opaque = w_row[c];
      end
    end
  end

  assign hit   = r_live.enable && w_in_x && w_in_y && w_opaque;
  assign color = r_live.color;

  logic w_unused_data;
  assign w_unused_data = ^wr_data;

endmodule

`default_nettype wire

// File: rtl/multi_sprite_engine.sv
// ============================================================================
// Module      : multi_sprite_engine
// Description : N-channel sprite overlay with fixed priority and optional
//               collision detection (enabled by macro MSE_COLLISION_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_sprite_engine
  import mse_pkg::*;
#(
  parameter int NUM_SPRITES   = 4,
  parameter int SPRITE_WIDTH  = 12,
  parameter int SPRITE_HEIGHT = 12,
  parameter int COORD_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [COORD_W-1:0]     pixel_x,
  input  logic [COORD_W-1:0]     pixel_y,
  input  logic                   pixel_strobe,
  input  logic                   active,
  input  logic                   next_frame,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [7:0]             cfg_addr,
  input  logic [CFG_DATA_W-1:0]  cfg_data,
  output logic                   pix_valid,
  output logic [5:0]             pix_color,
  output logic [2:0]             pix_index,
  output logic [NUM_SPRITES-1:0] collision
);

  logic                        w_cfg_fire;
  logic [NUM_SPRITES-1:0]      w_wr_en;
  logic [NUM_SPRITES-1:0]      w_hits;
  logic [NUM_SPRITES-1:0][5:0] w_colors;

  // Writes are refused during the commit cycle so shadow and live never race.
  assign cfg_ready  = ~next_frame;
  assign w_cfg_fire = cfg_valid && cfg_ready;

  for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_chan
    assign w_wr_en[s] = w_cfg_fire && (cfg_addr[7:5] == 3'(s));

    mse_channel #(
      .SPRITE_IDX   (s),
      .SPRITE_WIDTH (SPRITE_WIDTH),
      .SPRITE_HEIGHT(SPRITE_HEIGHT),
      .COORD_W      (COORD_W)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .wr_en  (w_wr_en[s]),
      .wr_reg (cfg_addr[4:0]),
      .wr_data(cfg_data),
      .commit (next_frame),
      .pixel_x(pixel_x),
      .pixel_y(pixel_y),
      .hit    (w_hits[s]),
      .color  (w_colors[s])
    );
  end

  logic       w_any_hit;
  logic [5:0] w_win_color;
  logic [2:0] w_win_idx;

  // Walk from the top index down so the lowest-index hit is the last to land.
  always_comb begin
    w_any_hit   = 1'b0;
    w_win_color = '0;
    w_win_idx   = '0;
    for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
      if (w_hits[s]) begin
        w_any_hit   = 1'b1;
        w_win_color = w_colors[s];
        w_win_idx   = 3'(s);
      end
    end
  end

  logic       r_pix_valid;
  logic [5:0] r_pix_color;
  logic [2:0] r_pix_index;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_valid <= 1'b0;
      r_pix_color <= '0;
      r_pix_index <= '0;
    end else if (pixel_strobe) begin
      if (active) begin
        r_pix_valid <= w_any_hit;
        r_pix_color <= w_win_color;
        r_pix_index <= w_win_idx;
      end else begin
        r_pix_valid <= 1'b0;
        r_pix_color <= '0;
        r_pix_index <= '0;
      end
    end
  end

  assign pix_valid = r_pix_valid;
  assign pix_color = r_pix_color;
  assign pix_index = r_pix_index;

`ifdef MSE_COLLISION_EN
  logic [NUM_SPRITES-1:0] r_coll_acc;
  logic [NUM_SPRITES-1:0] r_collision;
  logic [NUM_SPRITES-1:0] w_acc_next;
  logic                   w_multi_hit;

  assign w_multi_hit = (w_hits & (w_hits - NUM_SPRITES'(1))) != '0;
  assign w_acc_next  = r_coll_acc | ((pixel_strobe && active && w_multi_hit) ? w_hits : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coll_acc  <= '0;
      r_collision <= '0;
    end else if (next_frame) begin
      r_collision <= w_acc_next;
      r_coll_acc  <= '0;
    end else begin
      r_coll_acc <= w_acc_next;
    end
  end

  assign collision = r_collision;
`else
  assign collision = '0;
`endif

endmodule

`default_nettype wire

// File: doc/multi_sprite_engine.md
MULTI_SPRITE_ENGINE -- requirements
Module: multi_sprite_engine

Interface
REQ-001 Parameter NUM_SPRITES, default 4: number of independent sprite channels, 1..8.
REQ-002 Parameter SPRITE_WIDTH, default 12: sprite columns, 1..16.
REQ-003 Parameter SPRITE_HEIGHT, default 12: sprite rows, 1..16.
REQ-004 Parameter COORD_W, default 8: width of downscaled pixel coordinates.
REQ-005 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 pixel_x  in  COORD_W  downscaled column of the current big pixel.
REQ-008 pixel_y  in  COORD_W  downscaled row of the current big pixel.
REQ-009 pixel_strobe  in  1  one-cycle pulse per big pixel; evaluate pixel_x/pixel_y.
REQ-010 active  in  1  high inside the visible area.
REQ-011 next_frame  in  1  one-cycle pulse at end of frame.
REQ-012 cfg_valid  in  1  configuration write request.
REQ-013 cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
REQ-014 cfg_addr  in  8  {sprite index[7:5], register[4:0]}.
REQ-015 cfg_data  in  16  write data, LSB-aligned.
REQ-016 pix_valid  out  1  a sprite pixel is opaque at the evaluated position.
REQ-017 pix_color  out  6  rrggbb of the winning sprite; 0 when pix_valid low.
REQ-018 pix_index  out  3  index of the winning sprite.
REQ-019 collision  out  NUM_SPRITES  per-sprite collision flags of the previous frame.

Function
REQ-020 Register map: 0 = x, 1 = y, 2 = color[5:0], 3 = enable[0], 16+r = bitmap row r, using bits [SPRITE_WIDTH-1:0]; bit c is column c.
REQ-021 Writes to x, y, color and enable SHALL go to shadow registers, copied to live registers in the cycle next_frame is high.
REQ-022 Bitmap row writes SHALL take effect in the cycle after acceptance.
REQ-023 Writes to an unmapped register, a row >= SPRITE_HEIGHT, or a sprite >= NUM_SPRITES SHALL be accepted and ignored.
REQ-024 cfg_ready SHALL be low exactly in the cycle next_frame is high, and high otherwise out of reset.
REQ-025 Sprite s is hit when all of the following hold: it is enabled, x <= pixel_x < x+SPRITE_WIDTH, y <= pixel_y < y+SPRITE_HEIGHT, and bitmap[pixel_y-y][pixel_x-x] = 1.
REQ-026 Bounds sums SHALL be computed in COORD_W+1 bits with no wrap-around, so sprites are clipped at the right and bottom edges.
REQ-027 The lowest-index hit sprite SHALL win; its color and index drive the outputs.
REQ-028 Outputs SHALL be registered and updated one cycle after pixel_strobe while active is high.
REQ-029 Outputs SHALL hold between strobes.
REQ-030 Outputs SHALL be forced to pix_valid = 0, pix_color = 0 and pix_index = 0 one cycle after a strobe with active low.
REQ-031 Collision accumulation: on each strobe with active high and two or more hits, the accumulator bit of every hit sprite SHALL be set.
REQ-032 On next_frame, collision SHALL load the accumulator OR the same-cycle hits, and the accumulator SHALL clear.
REQ-033 When pixel_strobe and next_frame coincide, the pixel SHALL be evaluated with pre-commit live registers.

Reset
REQ-034 Reset SHALL set pix_valid = 0, pix_color = 0, pix_index = 0, collision = 0, accumulator = 0 and cfg_ready = 1.
REQ-035 Reset SHALL set live and shadow registers of sprite s to x = 16*s, y = 8*s, color = 6'b110001, enable = (s == 0), and all bitmap rows to 0.
REQ-036 Reset assertion mid-frame or mid-write SHALL discard pending shadow values with no partial commit.

Configuration
REQ-037 Macro MSE_COLLISION_EN: when defined, REQ-031 and REQ-032 are implemented.
REQ-038 When MSE_COLLISION_EN is undefined, collision SHALL be constant 0 and no accumulator SHALL be synthesised.

Structure
REQ-039 Package mse_pkg SHALL hold the register offset constants, CFG_DATA_W = 16, the reset color, and a sprite_regs_t struct {x, y, color, enable}.
REQ-040 Sub-module mse_channel SHALL contain one sprite's registers, bitmap and hit logic, instantiated NUM_SPRITES times.
REQ-041 Priority and collision logic SHALL reside in the top module.

Verification
REQ-042 Reset, then a strobe at (0,0) after writing row 0 = 16'h0001 for sprite 0 -> one cycle later pix_valid = 1, pix_color = 6'b110001, pix_index = 0.
REQ-043 Write sprite 1 x = 40 without next_frame, then strobe at (40,8) -> sprite 1 not yet visible; after next_frame, visible if its bitmap bit is set.
REQ-044 Sprites 0 and 1 both enabled, opaque and overlapping at (20,10) -> pix_index = 0; collision = 4'b0011 after next_frame; collision = 0 after the following clean frame.
REQ-045 Sprite x = 250, SPRITE_WIDTH = 12, strobe at pixel_x = 2 -> pix_valid = 0, with no wrap-around.
REQ-046 cfg_valid held high across next_frame -> no write accepted in that cycle; the write is accepted the next cycle.
REQ-047 Build without MSE_COLLISION_EN, repeat REQ-044 -> collision stays 0 and priority is unchanged.
